// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive responder.
// Holds the data width and the RX and read state encodings.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   typedef enum logic {
      RIDLE,
      RWAIT
   } rd_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with async active-high reset.
// Ports: clk, reset, push/din, pop/dout, count, full, empty.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_rx_responder.sv
// UART receiver answering CPU read handshakes from a byte FIFO.
// Ports: clk, reset, uartRx in; uartReadReq/Ack/Data handshake;
// rxCount occupancy, rxFrameErr pulse, rxOverflow sticky.
// Define UART_RX_PARITY_EN for 8E1 frames (default 8N1).
module uart_rx_responder
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        uartRx,
   input  logic                        uartReadReq,
   output logic                        uartReadAck,
   output logic [UART_DATA_BITS-1:0]   uartReadData,
   output logic [$clog2(FIFO_DEPTH):0] rxCount,
   output logic                        rxFrameErr,
   output logic                        rxOverflow
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic rx_s1;
   logic rx_s2;
   logic rx_q;

   rx_state_t rx_state;
   rx_state_t rx_next;
   rd_state_t rd_state;
   rd_state_t rd_next;

   logic [CW-1:0]             cnt;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      cnt_clr;
   logic                      shift_en;
   logic                      frame_ok;
   logic                      frame_bad;
   logic                      frame_good;
   logic                      push_q;

   logic [UART_DATA_BITS-1:0] fifo_dout;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      pop;

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic par_en;

   assign frame_good = rx_s2 && (par_bit == ^shreg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       par_bit <= 1'b0;
      else if (par_en) par_bit <= rx_s2;
   end
`else
   assign frame_good = rx_s2;
`endif

   // rx_q trails rx_s2 by one clock for falling-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_q  <= 1'b1;
      end else begin
         rx_s1 <= uartRx;
         rx_s2 <= rx_s1;
         rx_q  <= rx_s2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_state <= IDLE;
      else       rx_state <= rx_next;
   end

   always_comb begin
      rx_next   = rx_state;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en    = 1'b0;
`endif
      case (rx_state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (rx_q && !rx_s2) rx_next = START;
         end
         START: begin
            if (cnt == HALF_M1) begin
               cnt_clr = 1'b1;
               rx_next = rx_s2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  rx_next = PARITY;
`else
                  rx_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == FULL_M1) begin
               cnt_clr = 1'b1;
               par_en  = 1'b1;
               rx_next = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_clr   = 1'b1;
               rx_next   = IDLE;
               frame_ok  = frame_good;
               frame_bad = !frame_good;
            end
         end
         default: rx_next = IDLE;
      endcase
   end

   // Push and error are registered: both land one clock after
   // the stop-bit sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         push_q     <= 1'b0;
         rxFrameErr <= 1'b0;
         rxOverflow <= 1'b0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + 1'b1;
         if (rx_state == IDLE) bit_idx <= '0;
         else if (shift_en)    bit_idx <= bit_idx + 1'b1;
         if (shift_en) shreg <= {rx_s2, shreg[UART_DATA_BITS-1:1]};
         push_q     <= frame_ok;
         rxFrameErr <= frame_bad;
         if (push_q && fifo_full) rxOverflow <= 1'b1;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (UART_DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .pop   (pop),
      .din   (shreg),
      .dout  (fifo_dout),
      .count (rxCount),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_state <= RIDLE;
      else       rd_state <= rd_next;
   end

   // One pop per req-high period; RWAIT waits for req to drop.
   always_comb begin
      rd_next = rd_state;
      pop     = 1'b0;
      case (rd_state)
         RIDLE: begin
            if (uartReadReq && !fifo_empty) begin
               pop     = 1'b1;
               rd_next = RWAIT;
            end
         end
         RWAIT: begin
            if (!uartReadReq) rd_next = RIDLE;
         end
         default: rd_next = RIDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uartReadAck  <= 1'b0;
         uartReadData <= '0;
      end else begin
         uartReadAck <= pop;
         if (pop) uartReadData <= fifo_dout;
      end
   end

endmodule

// File: tb/tb_uart_rx_responder.sv
// Directed bench for uart_rx_responder (16 clks/bit, depth 4).
// Table of frames plus hand sequences for multi-cycle cases.
module tb_uart_rx_responder;

   localparam int CPB = 16;
   localparam int DEP = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       uartRx = 1'b1;
   logic       uartReadReq = 1'b0;
   logic       uartReadAck;
   logic [7:0] uartReadData;
   logic [2:0] rxCount;
   logic       rxFrameErr;
   logic       rxOverflow;

   int checks = 0;
   int errors = 0;
   int ack_seen = 0;
   int ferr_seen = 0;

   logic [2:0] stop_cnt [16];
   logic       stop_err [16];
   logic       stop_ack [16];

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       pbad;
      logic       err;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl [$];

   uart_rx_responder #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .uartRx       (uartRx),
      .uartReadReq  (uartReadReq),
      .uartReadAck  (uartReadAck),
      .uartReadData (uartReadData),
      .rxCount      (rxCount),
      .rxFrameErr   (rxFrameErr),
      .rxOverflow   (rxOverflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (uartReadAck) ack_seen++;
      if (rxFrameErr)  ferr_seen++;
   end

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called just after a negedge. Records outputs at each negedge
   // of the stop bit; the DUT samples stop at offset 11.
   task automatic send_frame(input logic [7:0] d,
                             input logic stop,
                             input logic par);
      uartRx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uartRx = d[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      uartRx = par;
      repeat (CPB) @(negedge clk);
`else
      if (par) uartRx = 1'b0;
`endif
      uartRx = stop;
      for (int k = 0; k < 16; k++) begin
         stop_cnt[k] = rxCount;
         stop_err[k] = rxFrameErr;
         stop_ack[k] = uartReadAck;
         @(negedge clk);
      end
      uartRx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_read(output logic got,
                          output logic [7:0] d,
                          output int lat);
      got = 1'b0;
      d = 8'h00;
      lat = 0;
      uartReadReq = 1'b1;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (uartReadAck) begin
            got = 1'b1;
            d = uartReadData;
            lat = i;
         end
      end
      uartReadReq = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic       got;
   logic [7:0] dat;
   int         lat;
   int         f0;
   int         a0;
   int         esum;

   initial begin
      tbl.push_back('{8'hAB, 1'b1, 1'b0, 1'b0, 3'd1});
      tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b1, 3'd0});
      tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 3'd1});
      tbl.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 3'd1});
      tbl.push_back('{8'h80, 1'b1, 1'b0, 1'b0, 3'd1});
      tbl.push_back('{8'h55, 1'b0, 1'b0, 1'b1, 3'd0});
`ifdef UART_RX_PARITY_EN
      tbl.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 3'd0});
      tbl.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 3'd1});
      tbl.push_back('{8'h07, 1'b0, 1'b1, 1'b1, 3'd0});
`endif

      repeat (3) @(negedge clk);
      check("rst_ack", uartReadAck, 0);
      check("rst_data", uartReadData, 0);
      check("rst_cnt", rxCount, 0);
      check("rst_ferr", rxFrameErr, 0);
      check("rst_ovf", rxOverflow, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      foreach (tbl[n]) begin
         f0 = ferr_seen;
         send_frame(tbl[n].d, tbl[n].stop, (^tbl[n].d) ^ tbl[n].pbad);
         esum = 0;
         for (int k = 0; k < 16; k++) esum += int'(stop_err[k]);
         check($sformatf("v%0d_errw", n), esum, tbl[n].err);
         check($sformatf("v%0d_err11", n), stop_err[11], tbl[n].err);
         check($sformatf("v%0d_cnt11", n), stop_cnt[11], 0);
         check($sformatf("v%0d_cnt12", n), stop_cnt[12], tbl[n].cnt);
         check($sformatf("v%0d_ferr", n), ferr_seen - f0, tbl[n].err);
         do_read(got, dat, lat);
         check($sformatf("v%0d_got", n), got, tbl[n].cnt != 0);
         if (tbl[n].cnt != 0) begin
            check($sformatf("v%0d_data", n), dat, tbl[n].d);
            check($sformatf("v%0d_lat", n), lat, 1);
         end
         check($sformatf("v%0d_cnt0", n), rxCount, 0);
      end

      uartReadReq = 1'b1;
      repeat (5) @(negedge clk);
      a0 = ack_seen;
      send_frame(8'h5A, 1'b1, ^8'h5A);
      check("hold_ack12", stop_ack[12], 0);
      check("hold_ack13", stop_ack[13], 1);
      check("hold_data", uartReadData, 8'h5A);
      repeat (30) @(negedge clk);
      check("hold_one_ack", ack_seen - a0, 1);
      uartReadReq = 1'b0;
      repeat (3) @(negedge clk);
      check("hold_cnt", rxCount, 0);

      for (int b = 1; b <= 5; b++) begin
         send_frame(8'(b), 1'b1, ^8'(b));
      end
      check("ovf_cnt", rxCount, 4);
      check("ovf_flag", rxOverflow, 1);
      for (int b = 1; b <= 4; b++) begin
         do_read(got, dat, lat);
         check($sformatf("ovf_rd%0d", b), dat, b);
      end
      check("ovf_sticky", rxOverflow, 1);
      check("ovf_cnt0", rxCount, 0);

      send_frame(8'h99, 1'b1, ^8'h99);
      f0 = ferr_seen;
      uartRx = 1'b0;
      repeat (4) @(negedge clk);
      uartRx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_cnt", rxCount, 1);
      check("glitch_ferr", ferr_seen - f0, 0);

      uartRx = 1'b0;
      repeat (CPB) @(negedge clk);
      uartRx = 1'b1;
      repeat (CPB) @(negedge clk);
      uartRx = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_cnt", rxCount, 0);
      check("mid_ovf", rxOverflow, 0);
      check("mid_data", uartReadData, 0);
      check("mid_ack", uartReadAck, 0);
      check("mid_ferr", rxFrameErr, 0);
      uartRx = 1'b1;
      reset = 1'b0;
      repeat (CPB * 10) @(negedge clk);
      check("post_cnt", rxCount, 0);

      send_frame(8'hC3, 1'b1, ^8'hC3);
      check("c3_cnt", rxCount, 1);
      do_read(got, dat, lat);
      check("c3_got", got, 1);
      check("c3_data", dat, 8'hC3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_responder.md
Name: uart_rx_responder

Overview:
- Real UART receive path answering the CPU's uartReadReq/uartReadAck/uartReadData interface. The CPU is the initiator; this block is the responder.
- Deserialises 8N1 serial data on uartRx and buffers bytes in a small FIFO.
- Hands one byte to the CPU per read handshake.
- Replaces the always-ack fake receiver used in simulation. Sits beside the CPU at top level.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Legal range is 8 or more.
- FIFO_DEPTH, 16, receive FIFO entries. Must be a power of two, 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- uartRx  input  1  serial line, idle high, asynchronous to clk.
- uartReadReq  input  1  CPU read request, level.
- uartReadAck  output  1  one-cycle pulse; uartReadData is valid this cycle.
- uartReadData  output  8  byte popped from the FIFO. Holds its value until the next ack.
- rxCount  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- rxFrameErr  output  1  one-cycle pulse when a byte is dropped for a bad stop bit (or bad parity, see Optional Feature).
- rxOverflow  output  1  sticky flag. Set when a completed byte is dropped because the FIFO is full. Cleared only by reset.

Behaviour:
- Reset (async, active-high) clears the FIFO, both state machines and all outputs. Reset values: uartReadAck=0, uartReadData=8'h00, rxCount=0, rxFrameErr=0, rxOverflow=0. Synchroniser flops reset to 1.
- Reset mid-frame aborts the frame. A partial byte is never pushed.
- uartRx passes through a 2-flop synchroniser; all line decisions use the synchronised value.
- RX FSM states:
  - IDLE: a falling edge (sync value 1 then 0) goes to START with bit counter=0.
  - START: at CLKS_PER_BIT/2 cycles, re-sample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, push the byte. If 0, drop the byte and pulse rxFrameErr. Either way return to IDLE, which then waits for a falling edge. A line stuck low therefore cannot retrigger until it returns high.
- Push latency: the byte enters the FIFO, and rxCount increments, on the clock after the stop-bit sample.
- Full FIFO at push: drop the new byte, set rxOverflow, leave the FIFO contents unchanged.
- Read FSM states:
  - RIDLE: if uartReadReq=1 and the FIFO is non-empty, pop the head into uartReadData, pulse uartReadAck, go to RWAIT. This is one-cycle latency from the req sample to the ack.
  - RIDLE with the FIFO empty: stay and keep waiting while req is held. The ack fires one cycle after the first push.
  - RWAIT: ack=0. Stay until uartReadReq=0, then return to RIDLE.
  - Exactly one byte is delivered per req high period, no matter how long req is held.
- Simultaneous push and pop in one cycle are both performed; rxCount is unchanged.
- A push into an empty FIFO in the same cycle req is sampled does not produce an ack that cycle; the ack follows on the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty come from rxCount, so there is no pointer-equality ambiguity.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one even-parity bit. On parity mismatch the byte is dropped and rxFrameErr pulses after the stop sample; a stop-bit error also pulses it once.
- Undefined: the frame is 8N1, the PARITY state is absent, and there is no parity logic.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_BITS=8;
  - the rx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - the rd_state_t enum {RIDLE, RWAIT}.
- One sub-module, uart_rx_fifo: synchronous FIFO with push, pop, din, dout, count, full, empty and async reset.
- Synchroniser, bit timer and both FSMs stay in uart_rx_responder.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 8'hAB, then raise req → rxCount=1 one clock after the stop sample; ack pulses one cycle after req with data=8'hAB; rxCount returns to 0.
- Raise req with the FIFO empty and hold it, then send 8'h5A → ack exactly one cycle after the push with data=8'h5A; only one ack while req stays high.
- Send 8'h3C with the stop bit driven 0 → rxFrameErr pulses one cycle; rxCount stays 0; no ack on req.
- Send 8'h01 to 8'h05 with no reads → rxCount=4, rxOverflow=1 and stays 1; four reads return 01, 02, 03, 04.
- Drive a uartRx low glitch of 4 clocks → returns to IDLE, no byte, no error. Assert reset mid-DATA of a byte → rxCount=0 and all outputs at reset values; the next byte 8'hC3 is received correctly.
- With UART_RX_PARITY_EN defined: send 8'h07 with parity bit 0 (wrong) → rxFrameErr pulses, byte dropped. Send it with parity 1 → received.
